// File: rtl/adc_pkg.sv
// Shared types and default parameter values for the ADC SPI sequencer.
package adc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        QUIET
    } state_t;

    localparam int DEF_DATA_W     = 12;
    localparam int DEF_FRAME_BITS = 16;
    localparam int DEF_LEAD_BITS  = 4;
    localparam int DEF_NUM_CH     = 8;
    localparam int DEF_CH_W       = 3;
    localparam int DEF_ADDR_POS   = 2;
    localparam int DEF_CLK_DIV    = 4;
    localparam int DEF_CS_QUIET   = 2;

endpackage

// File: rtl/adc_spi_seq_if.sv
// Result stream towards the filter/DSP chain: tagged sample with valid/ready.
interface adc_spi_seq_if
    import adc_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CH_W   = DEF_CH_W
);

    logic [DATA_W-1:0] sample_data;
    logic [CH_W-1:0]   sample_ch;
    logic              sample_valid;
    logic              sample_ready;

    modport master (
        output sample_data,
        output sample_ch,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_data,
        input  sample_ch,
        input  sample_valid,
        output sample_ready
    );

endinterface

// File: rtl/adc_sclk_gen.sv
// SPI clock divider: sclk idles high, toggles every CLK_DIV clk cycles while
// clr is low. The tick strobes announce the edge that the next clk edge makes.
module adc_sclk_gen
    import adc_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic sclk,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int CNT_W = $clog2(CLK_DIV);

    logic [CNT_W-1:0] cnt;
    logic             half_done;

    assign half_done = (cnt == CNT_W'(CLK_DIV - 1));
    assign rise_tick = half_done && !sclk;
    assign fall_tick = half_done && sclk;

    // Half-period counter and sclk toggle; clear parks sclk high with the count at zero.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst || clr) begin
            cnt  <= '0;
            sclk <= 1'b1;
        end else if (half_done) begin
            cnt  <= '0;
            sclk <= ~sclk;
        end else begin
            cnt  <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/adc_spi_seq.sv
// ADC SPI frame master: drives cs_n/sclk/din, round-robins the channel mask,
// captures one result per frame and hands it out on a valid/ready stream.
// The ADC is pipelined, so each frame returns the channel addressed one frame earlier.
module adc_spi_seq
    import adc_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FRAME_BITS = DEF_FRAME_BITS,
    parameter int LEAD_BITS  = DEF_LEAD_BITS,
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int CH_W       = DEF_CH_W,
    parameter int ADDR_POS   = DEF_ADDR_POS,
    parameter int CLK_DIV    = DEF_CLK_DIV,
    parameter int CS_QUIET   = DEF_CS_QUIET
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [NUM_CH-1:0] ch_mask,
    output logic              cs_n,
    output logic              sclk,
    output logic              din,
    input  logic              dout_adc,
    adc_spi_seq_if.master     sample,
    output logic              overrun,
    input  logic              overrun_clr,
    output logic              busy
);

    localparam int BIT_W = $clog2(FRAME_BITS);
    localparam int Q_W   = $clog2(CS_QUIET + 1);

    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(FRAME_BITS - 1);
    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(LEAD_BITS + DATA_W - 1);
    localparam logic [Q_W-1:0]   LAST_Q    = Q_W'(CS_QUIET - 1);

    // Lowest enabled channel strictly above cur, else the lowest enabled channel.
    function automatic logic [CH_W-1:0] next_channel(input logic [CH_W-1:0]   cur,
                                                     input logic [NUM_CH-1:0] mask);
        logic [CH_W-1:0]   lowest;
        logic [CH_W-1:0]   above;
        logic              found_above;
        logic [NUM_CH-1:0] m;
        lowest      = '0;
        above       = '0;
        found_above = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            m = mask >> i;
            if (m[0]) begin
                lowest = CH_W'(i);
                if (i > int'(cur)) begin
                    above       = CH_W'(i);
                    found_above = 1'b1;
                end
            end
        end
        return found_above ? above : lowest;
    endfunction

    // Value of din during frame bit k: the address MSB-first inside its window, zero elsewhere.
    function automatic logic addr_bit(input logic [CH_W-1:0] addr, input int k);
        logic [CH_W-1:0] t;
        t = '0;
        if (k >= ADDR_POS && k < ADDR_POS + CH_W) begin
            t = addr << (k - ADDR_POS);
        end
        return t[CH_W-1];
    endfunction

    state_t            state;
    state_t            state_next;
    logic              go;
    logic              start_frame;
    logic              frame_end;
    logic              gen_clr;
    logic              rise_tick;
    logic              fall_tick;
    logic              in_data;
    logic [BIT_W-1:0]  bit_cnt;
    logic [Q_W-1:0]    q_cnt;
    logic [DATA_W-1:0] shreg;
    logic [CH_W-1:0]   ptr;
    logic [CH_W-1:0]   prev_ch;
    logic              prime;
    logic              done;

    assign go      = enable && (|ch_mask);
    assign in_data = (int'(bit_cnt) >= LEAD_BITS) && (int'(bit_cnt) < LEAD_BITS + DATA_W);
    assign gen_clr = !(state == SETUP || state == SHIFT) || frame_end;

    adc_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk       (clk),
        .rst       (rst),
        .clr       (gen_clr),
        .sclk      (sclk),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // FSM next state plus frame start/end strobes.
    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        state_next  = state;
        start_frame = 1'b0;
        frame_end   = 1'b0;
        case (state)
            IDLE: begin
                if (go) begin
                    state_next  = SETUP;
                    start_frame = 1'b1;
                end
            end
            SETUP: begin
                if (fall_tick) state_next = SHIFT;
            end
            SHIFT: begin
                if (fall_tick && bit_cnt == LAST_BIT) begin
                    state_next = QUIET;
                    frame_end  = 1'b1;
                end
            end
            QUIET: begin
                if (q_cnt == LAST_Q) begin
                    if (go) begin
                        state_next  = SETUP;
                        start_frame = 1'b1;
                    end else begin
                        state_next  = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Frame datapath: pins, bit/quiet counters, sequencer, capture shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_n    <= 1'b1;
            busy    <= 1'b0;
            din     <= 1'b0;
            bit_cnt <= '0;
            q_cnt   <= '0;
            shreg   <= '0;
            ptr     <= '0;
            prev_ch <= '0;
            prime   <= 1'b1;
            done    <= 1'b0;
        end else begin
            cs_n  <= !(state_next == SETUP || state_next == SHIFT);
            busy  <= (state_next != IDLE);
            done  <= 1'b0;
            q_cnt <= (state == QUIET) ? q_cnt + Q_W'(1) : '0;

            // ch_mask is looked at only here, once per frame.
            if (start_frame) begin
                ptr     <= next_channel(ptr, ch_mask);
                prev_ch <= ptr;
            end

            if (state == SETUP && fall_tick) begin
                bit_cnt <= '0;
                din     <= addr_bit(ptr, 0);
            end

            if (state == SHIFT) begin
                if (fall_tick) begin
                    if (bit_cnt == LAST_BIT) begin
                        din   <= 1'b0;
                        prime <= 1'b0;
                    end else begin
                        bit_cnt <= bit_cnt + BIT_W'(1);
                        din     <= addr_bit(ptr, int'(bit_cnt) + 1);
                    end
                end
                if (rise_tick && in_data) begin
                    shreg <= {shreg[DATA_W-2:0], dout_adc};
                end
                if (rise_tick && bit_cnt == LAST_DATA && !prime) begin
                    done <= 1'b1;
                end
            end

            if (state == QUIET && state_next == IDLE) begin
                prime <= 1'b1;
            end
        end
    end

    // Output register with valid/ready handshake and sticky overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample.sample_data  <= '0;
            sample.sample_ch    <= '0;
            sample.sample_valid <= 1'b0;
            overrun             <= 1'b0;
        end else begin
            if (done) begin
                sample.sample_data  <= shreg;
                sample.sample_ch    <= prev_ch;
                sample.sample_valid <= 1'b1;
            end else if (sample.sample_valid && sample.sample_ready) begin
                sample.sample_valid <= 1'b0;
            end

            // A fresh overwrite beats a simultaneous clear.
            if (done && sample.sample_valid && !sample.sample_ready) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adc_spi_seq.sv
// Directed bench for adc_spi_seq with a behavioural ADC that serves one
// queued word per frame and logs what the sequencer sends on din.
module tb_adc_spi_seq;

    logic       clk         = 1'b0;
    logic       rst         = 1'b1;
    logic       enable      = 1'b0;
    logic [7:0] ch_mask     = 8'h00;
    logic       overrun_clr = 1'b0;
    logic       dout_adc    = 1'b0;
    logic       cs_n;
    logic       sclk;
    logic       din;
    logic       overrun;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    adc_spi_seq_if #(.DATA_W(12), .CH_W(3)) smp ();

    adc_spi_seq dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .ch_mask     (ch_mask),
        .cs_n        (cs_n),
        .sclk        (sclk),
        .din         (din),
        .dout_adc    (dout_adc),
        .sample      (smp),
        .overrun     (overrun),
        .overrun_clr (overrun_clr),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // ---------------- ADC model ----------------
    logic [11:0] adc_words [0:63];
    int          frame_starts = 0;
    int          bit_k        = 0;
    int          cs_low       = 0;
    logic [11:0] adc_word     = '0;
    logic [15:0] din_word     = '0;
    logic        cs_prev      = 1'b1;
    logic        sclk_prev    = 1'b1;
    int          din_log[$];
    int          cslow_log[$];

    always @(negedge clk) begin : adc_model
        int          k;
        logic [11:0] sh;
        if (!cs_n && cs_prev) begin
            frame_starts <= frame_starts + 1;
            adc_word     <= adc_words[6'(frame_starts)];
            bit_k        <= -1;
            din_word     <= '0;
            cs_low       <= 1;
        end else if (!cs_n) begin
            cs_low <= cs_low + 1;
            if (sclk_prev && !sclk) begin
                k        = bit_k + 1;
                bit_k    <= k;
                din_word <= {din_word[14:0], din};
                sh       = '0;
                if (k >= 4 && k < 16) sh = adc_word << (k - 4);
                dout_adc <= sh[11];
            end
        end else if (!cs_prev) begin
            din_log.push_back(int'(din_word));
            cslow_log.push_back(cs_low);
            dout_adc <= 1'b0;
        end
        cs_prev   <= cs_n;
        sclk_prev <= sclk;
    end

    // ---------------- accepted-result monitor ----------------
    typedef struct {
        logic [11:0] data;
        logic [2:0]  ch;
        int          frame;
    } got_t;
    got_t got_q[$];

    always @(negedge clk) begin
        if (smp.sample_valid && smp.sample_ready) begin
            got_q.push_back('{data: smp.sample_data, ch: smp.sample_ch, frame: frame_starts});
        end
    end

    // ---------------- helpers ----------------
    int fs0;
    int g0;
    int d0;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        fs0 = frame_starts;
        g0  = got_q.size();
        d0  = din_log.size();
    endtask

    // Word returned by test-local frame i (1-based).
    task automatic set_word(input int i, input logic [11:0] w);
        adc_words[6'(fs0 + i - 1)] = w;
    endtask

    // Returns on the negedge just after cs_n falls.
    task automatic wait_cs_fall(input string tag);
        logic prev;
        bit   found;
        prev  = cs_n;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (prev && !cs_n) found = 1'b1;
            prev = cs_n;
        end
        if (!found) check({tag, "_cs_fall_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (!busy) found = 1'b1;
        end
        if (!found) check({tag, "_idle_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        int exp_ch[5];
        int exp_addr[6];
        exp_ch   = '{2, 5, 7, 2, 5};
        exp_addr = '{2, 5, 7, 2, 5, 7};
        for (int i = 0; i < 64; i++) adc_words[i] = '0;
        smp.sample_ready = 1'b0;

        // Reset values.
        do_reset();
        check("rst_cs_n",    32'(cs_n),             32'd1);
        check("rst_sclk",    32'(sclk),             32'd1);
        check("rst_din",     32'(din),              32'd0);
        check("rst_data",    32'(smp.sample_data),  32'd0);
        check("rst_ch",      32'(smp.sample_ch),    32'd0);
        check("rst_valid",   32'(smp.sample_valid), 32'd0);
        check("rst_overrun", 32'(overrun),          32'd0);
        check("rst_busy",    32'(busy),             32'd0);

        // Test 1: single channel, priming frame discarded, cs_n low 132 cycles.
        do_reset();
        ch_mask = 8'h01;
        smp.sample_ready = 1'b1;
        set_word(1, 12'hA5C);
        set_word(2, 12'hA5C);
        enable = 1'b1;
        wait_cs_fall("t1");
        check("t1_busy", 32'(busy), 32'd1);
        wait_cs_fall("t1");
        enable = 1'b0;
        wait_idle("t1");
        check("t1_count", 32'(got_q.size() - g0), 32'd1);
        check("t1_data",  32'(got_q[g0].data),    32'hA5C);
        check("t1_ch",    32'(got_q[g0].ch),      32'd0);
        check("t1_frame", 32'(got_q[g0].frame - fs0), 32'd2);
        check("t1_cslow0", 32'(cslow_log[d0]),     32'd132);
        check("t1_cslow1", 32'(cslow_log[d0 + 1]), 32'd132);

        // Test 2: round-robin over channels 2,5,7 with the address one frame ahead.
        do_reset();
        ch_mask = 8'b1010_0100;
        smp.sample_ready = 1'b1;
        for (int i = 1; i <= 6; i++) set_word(i, 12'(32'h111 * i));
        enable = 1'b1;
        for (int i = 0; i < 6; i++) wait_cs_fall("t2");
        enable = 1'b0;
        wait_idle("t2");
        check("t2_count", 32'(got_q.size() - g0), 32'd5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t2_ch%0d", i),   32'(got_q[g0 + i].ch),   32'(exp_ch[i]));
            check($sformatf("t2_data%0d", i), 32'(got_q[g0 + i].data), 32'h111 * 32'(i + 2));
        end
        for (int i = 0; i < 6; i++) begin
            check($sformatf("t2_din_addr%0d", i), (32'(din_log[d0 + i]) >> 11) & 32'h7, 32'(exp_addr[i]));
            check($sformatf("t2_din_zero%0d", i), 32'(din_log[d0 + i]) & ~32'h3800,     32'd0);
        end

        // Test 3: all-ones and LSB-only words.
        do_reset();
        ch_mask = 8'h01;
        smp.sample_ready = 1'b1;
        set_word(1, 12'h5A5);
        set_word(2, 12'hFFF);
        set_word(3, 12'h001);
        enable = 1'b1;
        for (int i = 0; i < 3; i++) wait_cs_fall("t3");
        enable = 1'b0;
        wait_idle("t3");
        check("t3_count", 32'(got_q.size() - g0), 32'd2);
        check("t3_fff",   32'(got_q[g0].data),     32'hFFF);
        check("t3_001",   32'(got_q[g0 + 1].data), 32'h001);

        // Test 4: overwrite, overrun clear alone, clear colliding with an overwrite.
        do_reset();
        ch_mask = 8'h01;
        smp.sample_ready = 1'b0;
        set_word(1, 12'hBAD);
        set_word(2, 12'h123);
        set_word(3, 12'h456);
        set_word(4, 12'h789);
        enable = 1'b1;
        for (int i = 0; i < 3; i++) wait_cs_fall("t4");
        check("t4_pend_valid", 32'(smp.sample_valid), 32'd1);
        check("t4_pend_data",  32'(smp.sample_data),  32'h123);
        check("t4_pend_ovr",   32'(overrun),          32'd0);
        repeat (129) @(negedge clk);
        check("t4_ovw_data",  32'(smp.sample_data),  32'h456);
        check("t4_ovw_valid", 32'(smp.sample_valid), 32'd1);
        check("t4_ovw_ovr",   32'(overrun),          32'd1);
        wait_cs_fall("t4");
        repeat (10) @(negedge clk);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        check("t4_clr_alone", 32'(overrun), 32'd0);
        repeat (117) @(negedge clk);
        check("t4_pre_load_data", 32'(smp.sample_data), 32'h456);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        check("t4_clr_collide_ovr", 32'(overrun),         32'd1);
        check("t4_load_data",       32'(smp.sample_data), 32'h789);
        enable = 1'b0;
        smp.sample_ready = 1'b1;
        @(negedge clk);
        check("t4_valid_drop", 32'(smp.sample_valid), 32'd0);
        wait_idle("t4");

        // Test 5: enable drops at frame bit 8, then re-enable with a fresh priming frame.
        do_reset();
        ch_mask = 8'h01;
        smp.sample_ready = 1'b1;
        set_word(1, 12'hBAD);
        set_word(2, 12'h3C3);
        set_word(3, 12'hAAA);
        set_word(4, 12'h555);
        enable = 1'b1;
        wait_cs_fall("t5");
        wait_cs_fall("t5");
        repeat (70) @(negedge clk);
        enable = 1'b0;
        wait_idle("t5");
        check("t5_count",  32'(got_q.size() - g0), 32'd1);
        check("t5_data",   32'(got_q[g0].data),    32'h3C3);
        check("t5_cs_n",   32'(cs_n),              32'd1);
        check("t5_sclk",   32'(sclk),              32'd1);
        check("t5_frames", 32'(frame_starts - fs0), 32'd2);
        enable = 1'b1;
        wait_cs_fall("t5");
        wait_cs_fall("t5");
        enable = 1'b0;
        wait_idle("t5");
        check("t5_re_count", 32'(got_q.size() - g0),     32'd2);
        check("t5_re_data",  32'(got_q[g0 + 1].data),    32'h555);
        check("t5_re_frame", 32'(got_q[g0 + 1].frame - fs0), 32'd4);

        // Test 6: rst at frame bit 10 with a result pending.
        do_reset();
        ch_mask = 8'h01;
        smp.sample_ready = 1'b0;
        set_word(1, 12'hBAD);
        set_word(2, 12'h777);
        set_word(3, 12'h888);
        enable = 1'b1;
        for (int i = 0; i < 3; i++) wait_cs_fall("t6");
        check("t6_pend_valid", 32'(smp.sample_valid), 32'd1);
        repeat (86) @(negedge clk);
        rst    = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        check("t6_cs_n",  32'(cs_n),             32'd1);
        check("t6_sclk",  32'(sclk),             32'd1);
        check("t6_valid", 32'(smp.sample_valid), 32'd0);
        check("t6_busy",  32'(busy),             32'd0);
        rst = 1'b0;
        smp.sample_ready = 1'b1;
        repeat (300) @(negedge clk);
        check("t6_no_result", 32'(got_q.size() - g0), 32'd0);
        check("t6_valid_end", 32'(smp.sample_valid),  32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
